// File: rtl/mmio_route4.sv
// mmio_route4: single-outstanding MMIO router from one CPU data port to four targets.
// Two address bits pick the target; the CPU sees data/err with a one-cycle done pulse.
module mmio_route4 #(
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         m_req,
  input  logic         m_we,
  input  logic [31:0]  m_addr,
  input  logic [31:0]  m_wdata,
  output logic         m_ready,
  output logic         m_done,
  output logic [31:0]  m_rdata,
  output logic         m_err,
  output logic [3:0]   s_req,
  output logic         s_we,
  output logic [31:0]  s_addr,
  output logic [31:0]  s_wdata,
  input  logic [3:0]   s_ack,
  input  logic [127:0] s_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [1:0]    sel;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          acked;
  logic          timed_out;

  assign accept    = (state == IDLE) && m_req;
  assign acked     = (state == BUSY) && s_ack[sel];
  // An ack on the last allowed cycle takes priority over the timeout.
  assign timed_out = (state == BUSY) && !s_ack[sel] && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = accept ? BUSY : IDLE;
      BUSY:    next_state = (acked || timed_out) ? DONE : BUSY;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    m_ready = 1'b0;
    m_done  = 1'b0;
    s_req   = 4'b0000;
    case (state)
      IDLE:    m_ready = 1'b1;
      BUSY:    s_req   = 4'b0001 << sel;
      DONE:    m_done  = 1'b1;
      default: m_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel     <= 2'd0;
      cnt     <= '0;
      s_we    <= 1'b0;
      s_addr  <= 32'd0;
      s_wdata <= 32'd0;
      m_rdata <= 32'd0;
      m_err   <= 1'b0;
    end else begin
      if (accept) begin
        sel     <= m_addr[SEL_LSB+1:SEL_LSB];
        cnt     <= '0;
        s_we    <= m_we;
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
      end else if (acked) begin
        m_rdata <= s_we ? 32'd0 : s_rdata[{sel, 5'd0} +: 32];
        m_err   <= 1'b0;
      end else if (timed_out) begin
        m_rdata <= 32'd0;
        m_err   <= 1'b1;
      end else if (state == BUSY) begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mmio_route4.sv
// tb_mmio_route4: directed stimulus with a transaction-level reference model
// compared against the router every cycle, plus literal per-test expectations.
module tb_mmio_route4;
  localparam int TIMEOUT = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         m_req = 1'b0;
  logic         m_we = 1'b0;
  logic [31:0]  m_addr = 32'd0;
  logic [31:0]  m_wdata = 32'd0;
  logic         m_ready, m_done, m_err, s_we;
  logic [31:0]  m_rdata, s_addr, s_wdata;
  logic [3:0]   s_req;
  logic [3:0]   s_ack = 4'b0000;
  logic [127:0] s_rdata = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_AAAA};

  mmio_route4 #(.SEL_LSB(28), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_done(m_done), .m_rdata(m_rdata),
    .m_err(m_err), .s_req(s_req), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_ack(s_ack), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: one outstanding transaction, finished by the selected ack or
  // after TIMEOUT busy cycles, followed by exactly one done cycle.
  bit          md_busy = 1'b0;
  bit          md_done = 1'b0;
  int          busy_n = 0;
  logic [1:0]  mt_sel = 2'd0;
  logic        mt_we = 1'b0;
  logic [31:0] mt_addr = 32'd0;
  logic [31:0] mt_wdata = 32'd0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_err = 1'b0;
  int          n_accept = 0;
  int          n_done = 0;
  bit          cmp_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md_busy <= 1'b0; md_done <= 1'b0; exp_rdata <= 32'd0; exp_err <= 1'b0;
      mt_we <= 1'b0; mt_addr <= 32'd0; mt_wdata <= 32'd0;
    end else begin
      md_done <= 1'b0;
      if (!md_busy && !md_done && m_req) begin
        md_busy <= 1'b1; busy_n <= 1; n_accept <= n_accept + 1;
        mt_we <= m_we; mt_addr <= m_addr; mt_wdata <= m_wdata; mt_sel <= m_addr[29:28];
      end else if (md_busy) begin
        if (s_ack[mt_sel]) begin
          md_busy <= 1'b0; md_done <= 1'b1; exp_err <= 1'b0;
          exp_rdata <= mt_we ? 32'd0 : s_rdata[mt_sel*32 +: 32];
        end else if (busy_n == TIMEOUT) begin
          md_busy <= 1'b0; md_done <= 1'b1; exp_err <= 1'b1; exp_rdata <= 32'd0;
        end else begin
          busy_n <= busy_n + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_ready", m_ready, !md_busy && !md_done);
      chk("m_done", m_done, md_done);
      chk("s_req", s_req, md_busy ? (4'b0001 << mt_sel) : 4'b0000);
      chk("m_rdata", m_rdata, exp_rdata);
      chk("m_err", m_err, exp_err);
      chk("s_we", s_we, mt_we);
      chk("s_addr", s_addr, mt_addr);
      chk("s_wdata", s_wdata, mt_wdata);
      if (m_done) n_done++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one request from IDLE; ack_bits drive s_ack from busy cycle ack_delay+1 on.
  task automatic do_txn(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] ack_bits,
                        input int ack_delay, input int exp_req,
                        input logic [31:0] exp_data, input logic exp_e);
    int req_cycles;
    int done_at;
    req_cycles = 0;
    done_at = -1;
    m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; s_ack = 4'b0000;
    @(negedge clk);
    chk({name, "_accept_ready"}, m_ready, 1'b1);
    next_cycle();
    m_req = 1'b0;
    for (int c = 1; c <= 40 && done_at < 0; c++) begin
      s_ack = (ack_delay >= 0 && c - 1 >= ack_delay) ? ack_bits : 4'b0000;
      @(negedge clk);
      if (s_req != 4'b0000) req_cycles++;
      if (m_done) done_at = c;
      next_cycle();
    end
    s_ack = 4'b0000;
    chk({name, "_req_cycles"}, req_cycles, exp_req);
    chk({name, "_done_cycle"}, done_at, exp_req + 1);
    chk({name, "_rdata"}, m_rdata, exp_data);
    chk({name, "_err"}, m_err, exp_e);
    chk({name, "_s_wdata"}, s_wdata, wdata);
    @(negedge clk);
    chk({name, "_ready_after"}, m_ready, 1'b1);
    next_cycle();
  endtask

  int dones_before;
  int acc_c[$];
  int done_c[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_ready", m_ready, 1'b1);
    chk("rst_s_req", s_req, 4'b0000);
    chk("rst_m_done", m_done, 1'b0);
    chk("rst_m_rdata", m_rdata, 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    next_cycle();
    rst = 1'b0;
    cmp_en = 1'b1;
    next_cycle();

    do_txn("rd_imm", 1'b0, 32'h2000_0010, 32'd0, 4'b0100, 0, 1, 32'hDEAD_BEEF, 1'b0);
    do_txn("wr_late", 1'b1, 32'h1000_0004, 32'h1234_5678, 4'b0010, 5, 6, 32'd0, 1'b0);
    do_txn("tmo", 1'b0, 32'h3000_0000, 32'd0, 4'b0000, -1, 15, 32'd0, 1'b1);
    do_txn("ack15", 1'b0, 32'h3000_0008, 32'd0, 4'b1000, 14, 15, 32'h3333_3333, 1'b0);
    do_txn("ack_other", 1'b0, 32'h3000_0000, 32'd0, 4'b0001, 2, 15, 32'd0, 1'b1);

    // Reset in the third busy cycle aborts the request silently.
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h1000_0000; s_ack = 4'b0000;
    next_cycle();
    m_req = 1'b0;
    next_cycle();
    next_cycle();
    dones_before = n_done;
    rst = 1'b1;
    #1;
    chk("rst_busy_s_req", s_req, 4'b0000);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy_ready", m_ready, 1'b1);
    next_cycle();
    chk("rst_busy_no_done", n_done, dones_before);
    do_txn("post_rst", 1'b0, 32'h1000_0000, 32'd0, 4'b0010, 0, 1, 32'h1111_1111, 1'b0);

    // Held request: two back-to-back reads, sel 0 then sel 1.
    s_ack = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0000; end
      if (c == 1) m_addr = 32'h1000_0000;
      if (c == 6) m_req = 1'b0;
      @(negedge clk);
      if (m_ready && m_req) acc_c.push_back(c);
      if (m_done) done_c.push_back(c);
      next_cycle();
    end
    s_ack = 4'b0000;
    chk("held_accepts", acc_c.size(), 2);
    chk("held_dones", done_c.size(), 2);
    if (acc_c.size() == 2 && done_c.size() == 2) begin
      chk("held_acc0", acc_c[0], 0);
      chk("held_done0", done_c[0], 2);
      chk("held_acc1_after_done", acc_c[1], done_c[0] + 1);
      chk("held_done1", done_c[1], 5);
    end
    chk("held_rdata", m_rdata, 32'h1111_1111);
    chk("total_dones", n_done, 8);
    chk("total_accepts", n_accept, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
